risc_alu: RTL and testbench
===========================

// Module: risc_alu
// PURPOSE
//  32-bit integer ALU for the RISC datapath execute stage. Decodes a 6-bit ALU opcode and computes logic/arithmetic
//  results, load/store effective addresses, the post-increment base value, and branch-compare flags.
//  Outputs are registered: one-cycle latency from an accepted input to its result.
// PARAMETERS
//  WIDTH   32   operand/result width in bits; opcode width is fixed at 6
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/opcode valid this cycle; sampled on rising clk
//  operand_a  in   WIDTH  source A (register rs / base address)
//  operand_b  in   WIDTH  source B (register rt / sign-extended immediate, supplied by the decoder)
//  opcode     in   6      ALU operation select
//  out_valid  out  1      registered outputs hold a new result
//  result     out  WIDTH  arithmetic/logic result or effective address
//  ret_reg    out  WIDTH  post-increment base write-back value
//  zero       out  1      result == 0
//  bgt        out  1      BGT compare true
//  blt        out  1      BLT compare true
// BEHAVIOUR
//  - Reset: async on rst_n low; all outputs are 0. On release, outputs hold 0 until the first accepted input.
//  - Accept: on a rising clk with in_valid=1, all outputs load from the combinational datapath; out_valid<=1.
//  - On a rising clk with in_valid=0: out_valid<=0. result/ret_reg/flags hold their previous values.
//  - Opcode map; all arithmetic is unsigned modulo 2^WIDTH, and carry/overflow are discarded:
//      0x00 AND   result=A&B       0x01 ADD  result=A+B       0x02 SUB  result=A-B
//      0x03 ANDI  result=A&B       0x04 ADDI result=A+B       0x05 LW   result=A+B
//      0x06 LWPI  result=A+B, ret_reg=A+1 (0xFFFFFFFF wraps to 0)
//      0x07 SW    result=A+B
//      0x08 BGT   result=A-B, bgt=(B>A) unsigned
//      0x09 BLT   result=A-B, blt=(B<A) unsigned
//      0x0A BEQ   result=A-B   (taken when zero=1)
//      0x0B BNE   result=A-B   (taken when zero=0)
//      others     result=0
//  - ret_reg=0 for every opcode except 0x06.
//  - bgt is 0 for every opcode except 0x08; blt is 0 for every opcode except 0x09.
//  - zero=(result==0) for every opcode, including the default case, where zero=1.
//  - All outputs are registered from the same edge, so there is no cross-cycle skew between result and flags.
//  - Reset asserted mid-operation: outputs clear immediately (async); a pending accepted input is discarded.
// STRUCTURE
//  - Package alu_pkg: localparams for the 12 opcodes (OP_AND..OP_BNE) and ALU_W=32.
//  - Sub-module alu_datapath: purely combinational; opcode decode, adder/subtractor, AND, comparators, ret_reg
//    increment, and next-value flags.
//  - risc_alu: instantiates alu_datapath and holds the output registers plus the out_valid register.
// TESTING
//  1. rst_n=0 with random inputs -> all outputs 0. Release rst_n and hold in_valid=0 for 3 cycles -> outputs
//     stay 0.
//  2. A=2, B=3, op=0x01 -> next cycle result=5, zero=0, out_valid=1. Same operands with op=0x00 -> result=2.
//     Same operands with op=0x02 -> result=0xFFFFFFFF.
//  3. A=2, B=3, op=0x06 -> result=5, ret_reg=3. A=0xFFFFFFFF, B=1, op=0x06 -> result=0, ret_reg=0, zero=1.
//  4. A=2, B=3: op=0x08 -> bgt=1, blt=0; op=0x09 -> bgt=0, blt=0. A=3, B=2, op=0x09 -> blt=1.
//  5. A=B=7: op=0x0A -> zero=1; op=0x0B -> zero=1. A=7, B=8, op=0x0B -> zero=0.
//     A=2, B=3, op=0x0C -> result=0, zero=1.
//  6. Back-to-back valid inputs for opcodes 0x01..0x0C -> one result per cycle in order.
//     Pulse rst_n low mid-stream -> outputs clear asynchronously.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared width and 6-bit opcode encodings for the RISC execute ALU.
// Revision: 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_W = 32;

    localparam logic [5:0] OP_AND  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_ANDI = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h05;
    localparam logic [5:0] OP_LWPI = 6'h06;
    localparam logic [5:0] OP_SW   = 6'h07;
    localparam logic [5:0] OP_BGT  = 6'h08;
    localparam logic [5:0] OP_BLT  = 6'h09;
    localparam logic [5:0] OP_BEQ  = 6'h0A;
    localparam logic [5:0] OP_BNE  = 6'h0B;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_datapath.sv
`default_nettype none
// ============================================================================
// Module  : alu_datapath
// Brief   : Combinational opcode decode, arithmetic/logic, compare flags and
//           post-increment base value feeding the ALU output registers.
// Revision: 1.0 - initial release
// ============================================================================
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [5:0]       i_opcode,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_ret_reg,
    output logic             o_zero,
    output logic             o_bgt,
    output logic             o_blt
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] w_inc;

    // Carries are intentionally dropped: all arithmetic wraps modulo 2^WIDTH.
    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_and  = i_a & i_b;
    assign w_inc  = i_a + {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        o_result  = '0;
        o_ret_reg = '0;
        o_bgt     = 1'b0;
        o_blt     = 1'b0;
        case (i_opcode)
            OP_AND, OP_ANDI: o_result = w_and;
            OP_ADD, OP_ADDI, OP_LW, OP_SW: o_result = w_sum;
            OP_LWPI: begin
                o_result  = w_sum;
                o_ret_reg = w_inc;
            end
            OP_SUB, OP_BEQ, OP_BNE: o_result = w_diff;
            OP_BGT: begin
                o_result = w_diff;
                o_bgt    = (i_b > i_a);
            end
            OP_BLT: begin
                o_result = w_diff;
                o_blt    = (i_b < i_a);
            end
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule : alu_datapath
`default_nettype wire

// File: rtl/risc_alu.sv
`default_nettype none
// ============================================================================
// Module  : risc_alu
// Brief   : Execute-stage ALU with one-cycle registered result, post-increment
//           write-back value and branch-compare flags.
// Revision: 1.0 - initial release
// ============================================================================
module risc_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [5:0]       opcode,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] ret_reg,
    output logic             zero,
    output logic             bgt,
    output logic             blt
);

    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] w_ret_reg;
    logic             w_zero;
    logic             w_bgt;
    logic             w_blt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_ret_reg;
    logic             r_zero;
    logic             r_bgt;
    logic             r_blt;

    alu_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .i_a       (operand_a),
        .i_b       (operand_b),
        .i_opcode  (opcode),
        .o_result  (w_result),
        .o_ret_reg (w_ret_reg),
        .o_zero    (w_zero),
        .o_bgt     (w_bgt),
        .o_blt     (w_blt)
    );

    // Result and flags share one enable so they never skew across cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ret_reg   <= '0;
            r_zero      <= 1'b0;
            r_bgt       <= 1'b0;
            r_blt       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result  <= w_result;
                r_ret_reg <= w_ret_reg;
                r_zero    <= w_zero;
                r_bgt     <= w_bgt;
                r_blt     <= w_blt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign ret_reg   = r_ret_reg;
    assign zero      = r_zero;
    assign bgt       = r_bgt;
    assign blt       = r_blt;

endmodule : risc_alu
`default_nettype wire

// File: tb/tb_risc_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_risc_alu
// Brief   : Directed, table-driven self-checking bench for risc_alu.
// Revision: 1.0 - initial release
// ============================================================================
module tb_risc_alu;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] res;
        logic [31:0] ret;
        logic        z;
        logic        gt;
        logic        lt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [5:0]  opcode;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] ret_reg;
    logic        zero;
    logic        bgt;
    logic        blt;

    int checks;
    int failures;

    risc_alu #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .result    (result),
        .ret_reg   (ret_reg),
        .zero      (zero),
        .bgt       (bgt),
        .blt       (blt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".result"},    result,             32'd0);
        chk({tag, ".ret_reg"},   ret_reg,            32'd0);
        chk({tag, ".zero"},      {31'd0, zero},      32'd0);
        chk({tag, ".bgt"},       {31'd0, bgt},       32'd0);
        chk({tag, ".blt"},       {31'd0, blt},       32'd0);
    endtask

    // Drives one vector, clocks it in, and checks the registered outputs.
    task automatic run_vec(input vec_t v, input string tag);
        in_valid  = 1'b1;
        operand_a = v.a;
        operand_b = v.b;
        opcode    = v.op;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"},    result,             v.res);
        chk({tag, ".ret_reg"},   ret_reg,            v.ret);
        chk({tag, ".zero"},      {31'd0, zero},      {31'd0, v.z});
        chk({tag, ".bgt"},       {31'd0, bgt},       {31'd0, v.gt});
        chk({tag, ".blt"},       {31'd0, blt},       {31'd0, v.lt});
    endtask

    vec_t dir_tbl[16];
    vec_t stream_tbl[12];

    initial begin
        checks   = 0;
        failures = 0;

        //             a             b             op     res           ret           z     gt    lt
        dir_tbl[0]  = '{32'd2,        32'd3,        6'h01, 32'd5,        32'd0,        1'b0, 1'b0, 1'b0};
        dir_tbl[1]  = '{32'd2,        32'd3,        6'h00, 32'd2,        32'd0,        1'b0, 1'b0, 1'b0};
        dir_tbl[2]  = '{32'd2,        32'd3,        6'h02, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0};
        dir_tbl[3]  = '{32'd2,        32'd3,        6'h06, 32'd5,        32'd3,        1'b0, 1'b0, 1'b0};
        dir_tbl[4]  = '{32'hFFFFFFFF, 32'd1,        6'h06, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};
        dir_tbl[5]  = '{32'd2,        32'd3,        6'h08, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1'b0};
        dir_tbl[6]  = '{32'd2,        32'd3,        6'h09, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0};
        dir_tbl[7]  = '{32'd3,        32'd2,        6'h09, 32'd1,        32'd0,        1'b0, 1'b0, 1'b1};
        dir_tbl[8]  = '{32'd7,        32'd7,        6'h0A, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};
        dir_tbl[9]  = '{32'd7,        32'd7,        6'h0B, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};
        dir_tbl[10] = '{32'd7,        32'd8,        6'h0B, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b0, 1'b0};
        dir_tbl[11] = '{32'd2,        32'd3,        6'h0C, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};
        dir_tbl[12] = '{32'd5,        32'hC,        6'h03, 32'd4,        32'd0,        1'b0, 1'b0, 1'b0};
        dir_tbl[13] = '{32'h7FFFFFFF, 32'h10,       6'h06, 32'h8000000F, 32'h80000000, 1'b0, 1'b0, 1'b0};
        dir_tbl[14] = '{32'd3,        32'd3,        6'h08, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};
        dir_tbl[15] = '{32'h12345678, 32'h1,        6'h3F, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};

        // A=10, B=3 through opcodes 0x01..0x0C back to back.
        stream_tbl[0]  = '{32'd10, 32'd3, 6'h01, 32'd13, 32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[1]  = '{32'd10, 32'd3, 6'h02, 32'd7,  32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[2]  = '{32'd10, 32'd3, 6'h03, 32'd2,  32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[3]  = '{32'd10, 32'd3, 6'h04, 32'd13, 32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[4]  = '{32'd10, 32'd3, 6'h05, 32'd13, 32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[5]  = '{32'd10, 32'd3, 6'h06, 32'd13, 32'd11, 1'b0, 1'b0, 1'b0};
        stream_tbl[6]  = '{32'd10, 32'd3, 6'h07, 32'd13, 32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[7]  = '{32'd10, 32'd3, 6'h08, 32'd7,  32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[8]  = '{32'd10, 32'd3, 6'h09, 32'd7,  32'd0,  1'b0, 1'b0, 1'b1};
        stream_tbl[9]  = '{32'd10, 32'd3, 6'h0A, 32'd7,  32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[10] = '{32'd10, 32'd3, 6'h0B, 32'd7,  32'd0,  1'b0, 1'b0, 1'b0};
        stream_tbl[11] = '{32'd10, 32'd3, 6'h0C, 32'd0,  32'd0,  1'b1, 1'b0, 1'b0};

        // Reset held with random valid traffic: outputs must stay cleared.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            operand_a = $urandom;
            operand_b = $urandom;
            opcode    = 6'($urandom_range(0, 63));
            @(posedge clk);
            #1;
        end
        chk_all_zero("reset");

        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        chk_all_zero("idle_after_reset");

        for (int i = 0; i < 16; i++) begin
            run_vec(dir_tbl[i], $sformatf("dir%0d", i));
        end

        // Idle cycle: out_valid drops, data and flags hold the last result.
        in_valid  = 1'b0;
        operand_a = 32'd1;
        operand_b = 32'd1;
        opcode    = 6'h01;
        @(posedge clk);
        #1;
        chk("hold.out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold.result",    result,             32'd0);
        chk("hold.zero",      {31'd0, zero},      32'd1);

        run_vec(dir_tbl[13], "hold_src");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("hold2.out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold2.result",    result,             32'h8000000F);
        chk("hold2.ret_reg",   ret_reg,            32'h80000000);

        for (int i = 0; i < 12; i++) begin
            run_vec(stream_tbl[i], $sformatf("stream%0d", i));
        end

        // Mid-stream async reset: clears between edges, pending input discarded.
        run_vec(stream_tbl[8], "pre_rst");
        operand_a = 32'd100;
        operand_b = 32'd1;
        opcode    = 6'h01;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(posedge clk);
        #1;
        chk_all_zero("rst_held");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("rst_release");

        run_vec(stream_tbl[0], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_risc_alu
`default_nettype wire
